// File: rtl/synapse_pkg.sv
// Shared definitions for the synaptic connectivity store.
// Contents: FSM state encoding, default geometry (axons per core, config
// word width), and the derived word count / word-counter width.
package synapse_pkg;

  localparam int NUM_AXONS_DEF = 256;
  localparam int WORD_W_DEF    = 64;
  localparam int NUM_WORDS_DEF = NUM_AXONS_DEF / WORD_W_DEF;

  // Counter width that stays at least 1 bit even for a single-word vector.
  function automatic int cnt_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(NUM_WORDS_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/synapse_con_mem.sv
// Connection vector storage and lookup port.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   wr_en         write the word at wr_idx this cycle
//   wr_idx        word index; selects slice [wr_idx*WORD_W +: WORD_W]
//   wr_data       configuration word
//   loaded        full vector present; gates the read result
//   axon_number   lookup index
//   connection    registered connection bit, 0 while loaded=0
module synapse_con_mem
  import synapse_pkg::*;
#(
  parameter int NUM_AXONS = NUM_AXONS_DEF,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int NUM_WORDS = NUM_AXONS / WORD_W,
  parameter int CNT_W     = cnt_width(NUM_WORDS),
  parameter int AXON_W    = $clog2(NUM_AXONS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CNT_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              loaded,
  input  logic [AXON_W-1:0] axon_number,
  output logic              connection
);

  logic [NUM_AXONS-1:0] mem;

  // NOTE: this store is reset on purpose -- it is a flat register, not a RAM
  // macro, and a reset must leave no trace of a previous connectivity load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (wr_idx == CNT_W'(k)) begin
          mem[k*WORD_W +: WORD_W] <= wr_data;
        end
      end
    end
  end

  // Stale or partial contents never leak out: the bit is forced to 0
  // whenever the vector is not fully loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      connection <= 1'b0;
    end else begin
      connection <= loaded & mem[axon_number];
    end
  end

endmodule

// File: rtl/synapse_con_loader.sv
// Run-time loadable synaptic connectivity store for one neuron.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   cfg_start     pulse: begin or restart a load (wins over a same-cycle word)
//   cfg_valid     cfg_data valid
//   cfg_data      word k carries axons k*WORD_W .. k*WORD_W+WORD_W-1
//   cfg_ready     a word is accepted this cycle when cfg_valid is high
//   axon_number   lookup index
//   connection    registered lookup result (1-cycle latency)
//   loaded        full vector present, lookups valid
//   busy          load in progress
module synapse_con_loader
  import synapse_pkg::*;
#(
  parameter int NUM_AXONS = NUM_AXONS_DEF,
  parameter int WORD_W    = WORD_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_start,
  input  logic                         cfg_valid,
  input  logic [WORD_W-1:0]            cfg_data,
  output logic                         cfg_ready,
  input  logic [$clog2(NUM_AXONS)-1:0] axon_number,
  output logic                         connection,
  output logic                         loaded,
  output logic                         busy
);

  localparam int NUM_WORDS = NUM_AXONS / WORD_W;
  localparam int CNT_W     = cnt_width(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wr_en;

  // Status outputs decode the registered state directly, so they change
  // only on the edge that moves the FSM.
  assign cfg_ready = (state == LOAD);
  assign busy      = (state == LOAD);
  assign loaded    = (state == DONE);

  // A start pulse discards any word offered in the same cycle.
  assign wr_en = cfg_ready & cfg_valid & ~cfg_start;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (cfg_start) begin
      state <= LOAD;
      cnt   <= '0;
    end else if (wr_en) begin
      // Counter holds at the last index; the next start clears it.
      if (cnt == LAST_WORD) begin
        state <= DONE;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  synapse_con_mem #(
    .NUM_AXONS (NUM_AXONS),
    .WORD_W    (WORD_W)
  ) u_mem (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_idx      (cnt),
    .wr_data     (cfg_data),
    .loaded      (loaded),
    .axon_number (axon_number),
    .connection  (connection)
  );

endmodule

// File: tb/tb_synapse_con_loader.sv
// Directed self-checking bench for synapse_con_loader; lookup results are
// checked through an expected-value queue filled as lookups are driven.
module tb_synapse_con_loader;

  localparam int NUM_AXONS = 256;
  localparam int WORD_W    = 64;
  localparam int NUM_WORDS = NUM_AXONS / WORD_W;

  logic              clk;
  logic              rst;
  logic              cfg_start;
  logic              cfg_valid;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_ready;
  logic [7:0]        axon_number;
  logic              connection;
  logic              loaded;
  logic              busy;

  int total = 0;
  int bad   = 0;

  logic [NUM_AXONS-1:0] vec;       // expected memory contents
  logic                 exp_q[$];  // expected lookup results, in order
  logic                 got[NUM_AXONS];
  logic [WORD_W-1:0]    words[NUM_WORDS];

  synapse_con_loader #(
    .NUM_AXONS (NUM_AXONS),
    .WORD_W    (WORD_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_start   (cfg_start),
    .cfg_valid   (cfg_valid),
    .cfg_data    (cfg_data),
    .cfg_ready   (cfg_ready),
    .axon_number (axon_number),
    .connection  (connection),
    .loaded      (loaded),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  // Back-to-back load of four words; also checks the loaded edge and that
  // a lookup issued in the final handshake cycle still returns 0.
  task automatic load_b2b(input string tag, input logic [WORD_W-1:0] w0,
                          input logic [WORD_W-1:0] w1, input logic [WORD_W-1:0] w2,
                          input logic [WORD_W-1:0] w3);
    logic [WORD_W-1:0] w[NUM_WORDS];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    start_load();
    check({tag, " ready_after_start"}, 64'(cfg_ready), 64'd1);
    check({tag, " busy_after_start"}, 64'(busy), 64'd1);
    for (int k = 0; k < NUM_WORDS; k++) begin
      cfg_valid = 1'b1;
      cfg_data  = w[k];
      vec[k*WORD_W +: WORD_W] = w[k];
      if (k == NUM_WORDS - 1) axon_number = 8'd0;
      step();
      check($sformatf("%s loaded_after_word%0d", tag, k), 64'(loaded),
            64'(k == NUM_WORDS - 1));
    end
    cfg_valid = 1'b0;
    check({tag, " conn_on_loaded_edge"}, 64'(connection), 64'd0);
    check({tag, " busy_done"}, 64'(busy), 64'd0);
    check({tag, " ready_done"}, 64'(cfg_ready), 64'd0);
  endtask

  // Full lookup sweep: push the model bit as each index is driven, pop and
  // compare once the registered result is out.
  task automatic sweep(input string tag, input logic exp_loaded);
    for (int i = 0; i < NUM_AXONS; i++) begin
      axon_number = 8'(i);
      exp_q.push_back(exp_loaded ? vec[i] : 1'b0);
      step();
      got[i] = connection;
      check($sformatf("%s conn[%0d]", tag, i), 64'(connection), 64'(exp_q.pop_front()));
    end
    check({tag, " loaded"}, 64'(loaded), 64'(exp_loaded));
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0; axon_number = '0;
    vec = '0;
    words[0] = 64'hba502b6aaaac7467;
    words[1] = 64'hda869ec794438a23;
    words[2] = 64'h34da925752a6d292;
    words[3] = 64'heaafeaaa292b002b;
    #1;
    check("rst connection", 64'(connection), 64'd0);
    check("rst loaded", 64'(loaded), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst cfg_ready", 64'(cfg_ready), 64'd0);
    #11 rst = 1'b0;
    step();

    // Lookups before any load are all 0; offered words are ignored in IDLE.
    cfg_valid = 1'b1; cfg_data = '1;
    sweep("noload", 1'b0);
    check("noload cfg_ready", 64'(cfg_ready), 64'd0);
    cfg_valid = 1'b0;

    // Back-to-back load and full readback.
    load_b2b("b2b", words[0], words[1], words[2], words[3]);
    sweep("b2b", 1'b1);
    check("b2b axon0", 64'(got[0]), 64'd1);
    check("b2b axon3", 64'(got[3]), 64'd0);
    check("b2b axon64", 64'(got[64]), 64'd1);
    check("b2b axon255", 64'(got[255]), 64'd1);

    // cfg_valid toggling: four accepted words in eight cycles; garbage is
    // driven on the invalid cycles.
    start_load();
    begin
      int k = 0;
      for (int c = 0; c < 2 * NUM_WORDS; c++) begin
        if (c % 2 == 0) begin
          cfg_valid = 1'b1;
          cfg_data  = words[k];
          vec[k*WORD_W +: WORD_W] = words[k];
          k++;
        end else begin
          cfg_valid = 1'b0;
          cfg_data  = 64'hdead_beef_0bad_f00d;
        end
        step();
        check($sformatf("toggle loaded_c%0d", c), 64'(loaded), 64'(k == NUM_WORDS));
      end
    end
    cfg_valid = 1'b0;
    sweep("toggle", 1'b1);

    // Abort: two words, then start together with a third valid word.
    start_load();
    cfg_valid = 1'b1;
    cfg_data = 64'h0123456789abcdef; vec[0 +: WORD_W] = cfg_data; step();
    cfg_data = 64'hfedcba9876543210; vec[WORD_W +: WORD_W] = cfg_data; step();
    cfg_start = 1'b1; cfg_data = 64'hffff0000ffff0000;
    step();
    cfg_start = 1'b0;
    check("abort busy", 64'(busy), 64'd1);
    check("abort cfg_ready", 64'(cfg_ready), 64'd1);
    check("abort loaded", 64'(loaded), 64'd0);
    // A cleared counter needs exactly four more words.
    for (int k = 0; k < NUM_WORDS; k++) begin
      cfg_data = '1;
      vec[k*WORD_W +: WORD_W] = '1;
      step();
      check($sformatf("ones loaded_after_word%0d", k), 64'(loaded),
            64'(k == NUM_WORDS - 1));
    end
    // Words offered in DONE must not be written.
    cfg_data = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("done cfg_ready_c%0d", c), 64'(cfg_ready), 64'd0);
    end
    cfg_valid = 1'b0;
    sweep("ones", 1'b1);

    // Asynchronous reset mid-load, away from any clock edge.
    start_load();
    cfg_valid = 1'b1; cfg_data = 64'h5555aaaa5555aaaa;
    step();
    cfg_valid = 1'b0;
    check("midload busy", 64'(busy), 64'd1);
    #3 rst = 1'b1;
    #1;
    check("async busy", 64'(busy), 64'd0);
    check("async cfg_ready", 64'(cfg_ready), 64'd0);
    check("async loaded", 64'(loaded), 64'd0);
    check("async connection", 64'(connection), 64'd0);
    vec = '0;
    #2 rst = 1'b0;
    step();
    load_b2b("zeros", '0, '0, '0, '0);
    sweep("zeros", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/synapse_con_loader.md
# synapse_con_loader

Programmable synaptic connectivity store for one neuron. The block accepts the neuron's NUM_AXONS-bit connection vector as a stream of WORD_W-bit configuration words over a valid/ready handshake. It then answers per-axon connection lookups, with the same `axon_number` → `connection` contract as `neuron_con`. It is the write side of the connectivity path and replaces compile-time LUT INIT values with run-time loading from the core's configuration bus.

## Interface
- `NUM_AXONS`, 256, axons per core (multiple of WORD_W)
- `WORD_W`, 64, configuration word width; NUM_WORDS = NUM_AXONS/WORD_W
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `cfg_start`  in  1  one-cycle pulse that begins or restarts a load
- `cfg_valid`  in  1  cfg_data valid
- `cfg_data`  in  WORD_W  connection word; bit j = axon (k·WORD_W + j) for word k
- `cfg_ready`  out  1  block accepts a word this cycle
- `axon_number`  in  $clog2(NUM_AXONS)  lookup index
- `connection`  out  1  registered connection bit for the sampled axon_number
- `loaded`  out  1  full vector present, lookups valid
- `busy`  out  1  load in progress

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE: cfg_ready=0, loaded=0, busy=0. cfg_start → LOAD, word counter = 0.
- LOAD: cfg_ready=1, busy=1. A handshake (cfg_valid & cfg_ready) writes cfg_data into slice [cnt·WORD_W +: WORD_W] and increments cnt. A handshake with cnt = NUM_WORDS-1 → DONE. The counter never wraps past NUM_WORDS-1.
- DONE: loaded=1, busy=0, cfg_ready=0. cfg_start → LOAD, cnt=0, loaded drops. Old contents stay until overwritten but are not readable while loaded=0.
- cfg_start during LOAD aborts the load: cnt resets to 0 and already-written words are kept but will be overwritten. If cfg_start and a handshake occur in the same cycle, cfg_start wins and the word is discarded.
- cfg_valid outside LOAD is ignored. Data is never written while cfg_ready=0.
- Lookup: connection <= loaded ? mem[axon_number] : 0, evaluated every cycle.
- The memory is a flat NUM_AXONS-bit register. Axon i maps to mem bit i.

## Timing
- Reset values: state=IDLE, mem=0, cnt=0, connection=0, loaded=0, busy=0, cfg_ready=0.
- cfg_ready is a registered function of state, so it rises the cycle after cfg_start is sampled.
- Word acceptance takes 1 cycle per word. A full load is NUM_WORDS handshake cycles; back-to-back acceptance is supported with cfg_valid held high.
- loaded rises the cycle after the final handshake edge.
- Lookup latency is 1 cycle: the axon_number sampled at edge n appears on connection after edge n.
- A lookup in the same cycle that loaded rises returns 0. The first valid result follows the next edge.
- Reset mid-load returns to IDLE immediately, clears mem, and leaves loaded=0. There is no partial state retained.

## Structure
- Shared package `synapse_pkg`: the FSM state enum (IDLE/LOAD/DONE), default NUM_AXONS/WORD_W, and derived NUM_WORDS and counter width.
- One sub-module is natural: `synapse_con_mem`, which holds the write-slice enable by word index and the registered, loaded-gated read mux. The FSM and handshake stay in the top.

## Test plan
- Reset, then lookups with no load: axon_number 0..255 → connection=0, loaded=0, cfg_ready=0 throughout.
- Load words 64'hba502b6aaaac7467, 64'hda869ec794438a23, 64'h34da925752a6d292, 64'heaafeaaa292b002b back-to-back → loaded=1 one cycle after the 4th handshake.
- After that load, sweep axon_number 0..255 with one-cycle latency:
  - axon 0 → 1
  - axon 3 → 0
  - axon 64 → 1
  - axon 255 → 1
  - all 256 bits match the loaded words.
- Load with cfg_valid toggling 1/0 every cycle → exactly 4 accepted words in 8 cycles, same resulting vector as the back-to-back load.
- Abort test:
  - start a load, send 2 words, pulse cfg_start in the same cycle as a 3rd valid word → word discarded, cnt=0.
  - reload with all-ones words → every axon reads 1.
- Reset asserted asynchronously mid-load (after word 1) → outputs go to reset values without waiting for a clock edge; a subsequent full load of all-zeros reads 0 everywhere.
